// File: rtl/writeback_regfile_if.sv
// W-stage write-back bundle: the two write ports of the register file and
// the port-A result select. The enables are the only qualifiers: address and
// data are don't-care when the matching RegWrite*W is low. There is no
// back-pressure, so a write presented while its enable is high always
// commits on that clock edge.
interface writeback_regfile_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic [DATA_W-1:0] RD1W;
  logic [DATA_W-1:0] ALUResultW;
  logic [DATA_W-1:0] ReadDataW;
  logic              MemtoRegW;
  logic [ADDR_W-1:0] WA3W;
  logic [ADDR_W-1:0] WA4W;
  logic              RegWriteAW;
  logic              RegWriteBW;

  modport master (
    output RD1W, ALUResultW, ReadDataW, MemtoRegW,
    output WA3W, WA4W, RegWriteAW, RegWriteBW
  );

  modport slave (
    input RD1W, ALUResultW, ReadDataW, MemtoRegW,
    input WA3W, WA4W, RegWriteAW, RegWriteBW
  );
endinterface

// File: rtl/writeback_regfile.sv
// Write-back stage register file: 8x8, two write ports (A wins on address
// collision), two write-first bypassed read ports, and a per-register
// pending-write scoreboard that produces the decode stall.
module writeback_regfile #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  writeback_regfile_if.slave            wb,
  output logic [DATA_W-1:0]             ResultW,
  input  logic [ADDR_W-1:0]             RA1D,
  input  logic [ADDR_W-1:0]             RA2D,
  input  logic                          UseRA1D,
  input  logic                          UseRA2D,
  output logic [DATA_W-1:0]             RD1D,
  output logic [DATA_W-1:0]             RD2D,
  input  logic                          IssueD,
  input  logic [ADDR_W-1:0]             IssWA3D,
  input  logic [ADDR_W-1:0]             IssWA4D,
  input  logic                          IssWEAD,
  input  logic                          IssWEBD,
  output logic                          StallD,
  output logic                          SbErr,
  // Flattened scoreboard counters, register r at [r*CNT_W +: CNT_W].
  output logic [(2**ADDR_W)*CNT_W-1:0]  SbCntDbg
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [CNT_W-1:0]  cnt_q  [NREGS];
  logic [CNT_W-1:0]  cnt_d  [NREGS];
  logic [CNT_W-1:0]  eff    [NREGS];
  logic [NREGS-1:0]  inc;
  logic [NREGS-1:0]  dec;
  logic              err_set;

  assign ResultW = wb.MemtoRegW ? wb.ReadDataW : wb.ALUResultW;

  // Read ports: write-first bypass, port A has priority; forced to 0 in reset.
  always_comb begin
    RD1D = regs_q[RA1D];
    RD2D = regs_q[RA2D];
    if (wb.RegWriteBW && (wb.WA4W == RA1D)) RD1D = wb.RD1W;
    if (wb.RegWriteAW && (wb.WA3W == RA1D)) RD1D = ResultW;
    if (wb.RegWriteBW && (wb.WA4W == RA2D)) RD2D = wb.RD1W;
    if (wb.RegWriteAW && (wb.WA3W == RA2D)) RD2D = ResultW;
    if (!rst_n) begin
      RD1D = '0;
      RD2D = '0;
    end
  end

  // Register array: port B assigned first so port A overrides on collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      if (wb.RegWriteBW) regs_q[wb.WA4W] <= wb.RD1W;
      if (wb.RegWriteAW) regs_q[wb.WA3W] <= ResultW;
    end
  end

  // Scoreboard next state: issue increments, write-back decrements, saturate and flag errors.
  always_comb begin
    inc     = '0;
    dec     = '0;
    err_set = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      inc[r] = IssueD && ((IssWEAD && (IssWA3D == ADDR_W'(r))) ||
                          (IssWEBD && (IssWA4D == ADDR_W'(r))));
      dec[r] = (wb.RegWriteAW && (wb.WA3W == ADDR_W'(r))) ||
               (wb.RegWriteBW && (wb.WA4W == ADDR_W'(r)));
      // Wraps if a write-back arrives with no pending issue; that is the error case.
      eff[r]   = cnt_q[r] - CNT_W'(dec[r]);
      cnt_d[r] = cnt_q[r];
      if (inc[r] && !dec[r]) begin
        if (cnt_q[r] == '1) err_set = 1'b1;
        else                cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec[r] && !inc[r]) begin
        if (cnt_q[r] == '0) err_set = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  // Scoreboard state and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
      SbErr <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= cnt_d[r];
      if (err_set) SbErr <= 1'b1;
    end
  end

  // Decode stall: pending writes not retired by a write-back landing this cycle.
  always_comb begin
    StallD = (UseRA1D && (eff[RA1D] != '0)) || (UseRA2D && (eff[RA2D] != '0));
    if (!rst_n) StallD = 1'b0;
  end

  // Debug view of the counters.
  always_comb begin
    SbCntDbg = '0;
    for (int r = 0; r < NREGS; r++) SbCntDbg[r*CNT_W +: CNT_W] = cnt_q[r];
  end

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

  logic       clk;
  logic       rst_n;
  logic [7:0] ResultW;
  logic [2:0] RA1D, RA2D;
  logic       UseRA1D, UseRA2D;
  logic [7:0] RD1D, RD2D;
  logic       IssueD;
  logic [2:0] IssWA3D, IssWA4D;
  logic       IssWEAD, IssWEBD;
  logic       StallD, SbErr;
  logic [15:0] SbCntDbg;

  int errors;
  int checks;

  writeback_regfile_if #(.DATA_W(8), .ADDR_W(3)) wbif ();

  writeback_regfile #(.DATA_W(8), .ADDR_W(3), .CNT_W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb       (wbif),
    .ResultW  (ResultW),
    .RA1D     (RA1D),
    .RA2D     (RA2D),
    .UseRA1D  (UseRA1D),
    .UseRA2D  (UseRA2D),
    .RD1D     (RD1D),
    .RD2D     (RD2D),
    .IssueD   (IssueD),
    .IssWA3D  (IssWA3D),
    .IssWA4D  (IssWA4D),
    .IssWEAD  (IssWEAD),
    .IssWEBD  (IssWEBD),
    .StallD   (StallD),
    .SbErr    (SbErr),
    .SbCntDbg (SbCntDbg)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [1:0] cnt_of(input int r);
    return SbCntDbg[r*2 +: 2];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wbif.RegWriteAW = 1'b0;
    wbif.RegWriteBW = 1'b0;
    IssueD  = 1'b0;
    IssWEAD = 1'b0;
    IssWEBD = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int ra = 0; ra < 8; ra++) begin
      RA1D = 3'(ra);
      RA2D = 3'(7 - ra);
      #1;
      checks++;
      if (RD1D !== 8'h00 || RD2D !== 8'h00) begin
        errors++;
        $display("FAIL reset_read ra=%0d: got rd1=%h rd2=%h want 00 00", ra, RD1D, RD2D);
      end
    end
    // A write presented during reset must not show on the read ports nor stall.
    wbif.RegWriteAW = 1'b1; wbif.WA3W = 3'd1; wbif.MemtoRegW = 1'b1; wbif.ReadDataW = 8'hEE;
    RA1D = 3'd1; UseRA1D = 1'b1;
    #1;
    checks++;
    if (RD1D !== 8'h00 || StallD !== 1'b0) begin
      errors++;
      $display("FAIL reset_gate: got rd1=%h stall=%b want 00 0", RD1D, StallD);
    end
    idle();
    UseRA1D = 1'b0;
    #1;
    checks++;
    if (SbErr !== 1'b0 || SbCntDbg !== 16'h0000 || StallD !== 1'b0) begin
      errors++;
      $display("FAIL reset_sb: got err=%b cnt=%h stall=%b want 0 0000 0", SbErr, SbCntDbg, StallD);
    end
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (RD1D !== 8'h00) begin
      errors++;
      $display("FAIL reset_release_reg1: got %h want 00", RD1D);
    end
  endtask

  task automatic test_bypass();
    wbif.MemtoRegW = 1'b0; wbif.ALUResultW = 8'h3C; wbif.ReadDataW = 8'hA5;
    #1;
    checks++;
    if (ResultW !== 8'h3C) begin
      errors++;
      $display("FAIL resultw_alu: got %h want 3c", ResultW);
    end
    wbif.MemtoRegW = 1'b1;
    wbif.RegWriteAW = 1'b1; wbif.WA3W = 3'd5;
    IssueD = 1'b1; IssWEAD = 1'b1; IssWA3D = 3'd5;
    RA1D = 3'd5;
    #1;
    checks++;
    if (ResultW !== 8'hA5 || RD1D !== 8'hA5) begin
      errors++;
      $display("FAIL bypass_a: got result=%h rd1=%h want a5 a5", ResultW, RD1D);
    end
    step();
    idle();
    #1;
    checks++;
    if (RD1D !== 8'hA5 || cnt_of(5) !== 2'd0 || SbErr !== 1'b0) begin
      errors++;
      $display("FAIL stored_a: got rd1=%h cnt5=%0d err=%b want a5 0 0", RD1D, cnt_of(5), SbErr);
    end
  endtask

  task automatic test_dual_write();
    wbif.RegWriteAW = 1'b1; wbif.WA3W = 3'd2; wbif.MemtoRegW = 1'b0; wbif.ALUResultW = 8'h11;
    wbif.RegWriteBW = 1'b1; wbif.WA4W = 3'd2; wbif.RD1W = 8'h22;
    IssueD = 1'b1; IssWEAD = 1'b1; IssWA3D = 3'd2; IssWEBD = 1'b1; IssWA4D = 3'd2;
    RA2D = 3'd2;
    #1;
    checks++;
    if (RD2D !== 8'h11) begin
      errors++;
      $display("FAIL collide_bypass: got %h want 11", RD2D);
    end
    step();
    idle();
    #1;
    checks++;
    if (RD2D !== 8'h11 || cnt_of(2) !== 2'd0 || SbErr !== 1'b0) begin
      errors++;
      $display("FAIL collide_store: got rd2=%h cnt2=%0d err=%b want 11 0 0", RD2D, cnt_of(2), SbErr);
    end
    // Independent addresses on the two ports.
    wbif.RegWriteAW = 1'b1; wbif.WA3W = 3'd1; wbif.ALUResultW = 8'h77;
    wbif.RegWriteBW = 1'b1; wbif.WA4W = 3'd6; wbif.RD1W = 8'h66;
    IssueD = 1'b1; IssWEAD = 1'b1; IssWA3D = 3'd1; IssWEBD = 1'b1; IssWA4D = 3'd6;
    RA1D = 3'd6; RA2D = 3'd1;
    #1;
    checks++;
    if (RD1D !== 8'h66 || RD2D !== 8'h77) begin
      errors++;
      $display("FAIL split_bypass: got rd1=%h rd2=%h want 66 77", RD1D, RD2D);
    end
    step();
    idle();
    #1;
    checks++;
    if (RD1D !== 8'h66 || RD2D !== 8'h77 || SbErr !== 1'b0) begin
      errors++;
      $display("FAIL split_store: got rd1=%h rd2=%h err=%b want 66 77 0", RD1D, RD2D, SbErr);
    end
  endtask

  task automatic test_stall();
    IssueD = 1'b1; IssWEAD = 1'b1; IssWA3D = 3'd3;
    UseRA1D = 1'b1; RA1D = 3'd3;
    #1;
    checks++;
    if (StallD !== 1'b0) begin
      errors++;
      $display("FAIL stall_issue_cycle: got %b want 0", StallD);
    end
    step();
    idle();
    #1;
    checks++;
    if (cnt_of(3) !== 2'd1 || StallD !== 1'b1) begin
      errors++;
      $display("FAIL stall_pending: got cnt3=%0d stall=%b want 1 1", cnt_of(3), StallD);
    end
    step();
    checks++;
    if (StallD !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: got %b want 1", StallD);
    end
    UseRA1D = 1'b0;
    #1;
    checks++;
    if (StallD !== 1'b0) begin
      errors++;
      $display("FAIL stall_unused: got %b want 0", StallD);
    end
    UseRA2D = 1'b1; RA2D = 3'd3;
    #1;
    checks++;
    if (StallD !== 1'b1) begin
      errors++;
      $display("FAIL stall_port2: got %b want 1", StallD);
    end
    UseRA2D = 1'b0; UseRA1D = 1'b1;
    wbif.RegWriteAW = 1'b1; wbif.WA3W = 3'd3; wbif.MemtoRegW = 1'b0; wbif.ALUResultW = 8'h33;
    #1;
    checks++;
    if (StallD !== 1'b0 || RD1D !== 8'h33) begin
      errors++;
      $display("FAIL stall_wb_cycle: got stall=%b rd1=%h want 0 33", StallD, RD1D);
    end
    step();
    idle();
    #1;
    checks++;
    if (cnt_of(3) !== 2'd0 || StallD !== 1'b0 || RD1D !== 8'h33 || SbErr !== 1'b0) begin
      errors++;
      $display("FAIL stall_retired: got cnt3=%0d stall=%b rd1=%h err=%b want 0 0 33 0",
               cnt_of(3), StallD, RD1D, SbErr);
    end
    UseRA1D = 1'b0;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    // Both issue ports target reg 7: each issue counts once.
    IssueD = 1'b1; IssWEAD = 1'b1; IssWA3D = 3'd7; IssWEBD = 1'b1; IssWA4D = 3'd7;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_cnt = 2'(i);
      checks++;
      if (cnt_of(7) !== exp_cnt || SbErr !== 1'b0) begin
        errors++;
        $display("FAIL sat_count i=%0d: got cnt7=%0d err=%b want %0d 0", i, cnt_of(7), SbErr, exp_cnt);
      end
    end
    step();
    idle();
    checks++;
    if (cnt_of(7) !== 2'd3 || SbErr !== 1'b1) begin
      errors++;
      $display("FAIL sat_overflow: got cnt7=%0d err=%b want 3 1", cnt_of(7), SbErr);
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (SbErr !== 1'b0 || SbCntDbg !== 16'h0000) begin
      errors++;
      $display("FAIL pulse_clear: got err=%b cnt=%h want 0 0000", SbErr, SbCntDbg);
    end
    IssueD = 1'b1; IssWEAD = 1'b1; IssWA3D = 3'd4; IssWEBD = 1'b1; IssWA4D = 3'd0;
    wbif.RegWriteBW = 1'b1; wbif.WA4W = 3'd0; wbif.RD1W = 8'h5A;
    step();
    wbif.RegWriteBW = 1'b0; IssWEBD = 1'b0;
    step();
    idle();
    UseRA1D = 1'b1; RA1D = 3'd4; RA2D = 3'd0;
    #1;
    checks++;
    if (cnt_of(4) !== 2'd2 || StallD !== 1'b1 || RD2D !== 8'h5A || SbErr !== 1'b0) begin
      errors++;
      $display("FAIL mid_setup: got cnt4=%0d stall=%b rd2=%h err=%b want 2 1 5a 0",
               cnt_of(4), StallD, RD2D, SbErr);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (SbCntDbg !== 16'h0000 || RD2D !== 8'h00 || StallD !== 1'b0 || SbErr !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got cnt=%h rd2=%h stall=%b err=%b want 0000 00 0 0",
               SbCntDbg, RD2D, StallD, SbErr);
    end
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (StallD !== 1'b0 || RD2D !== 8'h00) begin
      errors++;
      $display("FAIL mid_release: got stall=%b rd2=%h want 0 00", StallD, RD2D);
    end
    UseRA1D = 1'b0;
    // Stale write-back after reset finds a zero counter.
    wbif.RegWriteAW = 1'b1; wbif.WA3W = 3'd1; wbif.MemtoRegW = 1'b0; wbif.ALUResultW = 8'h01;
    step();
    idle();
    checks++;
    if (SbErr !== 1'b1 || cnt_of(1) !== 2'd0) begin
      errors++;
      $display("FAIL underflow: got err=%b cnt1=%0d want 1 0", SbErr, cnt_of(1));
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    wbif.RD1W = '0; wbif.ALUResultW = '0; wbif.ReadDataW = '0; wbif.MemtoRegW = 1'b0;
    wbif.WA3W = '0; wbif.WA4W = '0;
    RA1D = '0; RA2D = '0; UseRA1D = 1'b0; UseRA2D = 1'b0;
    IssWA3D = '0; IssWA4D = '0;
    idle();

    test_reset();
    test_bypass();
    test_dual_write();
    test_stall();
    test_saturation();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
